// File: rtl/sev_seg_scanner.sv
// Binary-to-BCD display driver for an 8-digit seven-segment display.
// A sequential double-dabble engine converts a 27-bit amount; the scanner continuously cycles through the committed digits.
module sev_seg_scanner #(
    parameter int SCAN_DIV = 1
) (
    input  logic        clk_1ms,
    input  logic        rst,
    input  logic [26:0] amount,
    input  logic        load,
    input  logic        blank_lz,
    output logic        busy,
    output logic        overflow,
    output logic [3:0]  LED_Select,
    output logic [3:0]  LED_BCD
);
    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    localparam logic [26:0] MAX_AMOUNT = 27'd99_999_999;
    localparam logic [4:0]  LAST_ITER  = 5'd26;
    localparam logic [7:0]  DIV_LAST   = 8'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [26:0] bin_q, bin_d;
    logic [31:0] bcd_q, bcd_d;
    logic [4:0]  iter_q, iter_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;
    logic [31:0] digits_q, digits_d;
    logic [7:0]  div_q, div_d;
    logic [2:0]  sel_q, sel_d;
    logic [3:0]  led_bcd_q, led_bcd_d;

    logic [31:0] bcd_adj;
    logic [8:0]  zero_from;
    logic [3:0]  disp [8];
    logic [2:0]  sel_next;

    // zero_from[i] is set when committed digits i..7 are all zero.
    assign zero_from[8] = 1'b1;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
            assign zero_from[gi] = (digits_q[gi*4 +: 4] == 4'd0) && zero_from[gi+1];
            if (gi == 0) begin : g_lsd
                assign disp[gi] = digits_q[3:0];
            end else begin : g_upper
                assign disp[gi] = (blank_lz && zero_from[gi]) ? 4'hF : digits_q[gi*4 +: 4];
            end
        end
    endgenerate

    assign sel_next = sel_q + 3'd1;

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        iter_d    = iter_q;
        ovf_d     = ovf_q;
        digits_d  = digits_q;
        div_d     = div_q;
        sel_d     = sel_q;
        led_bcd_d = led_bcd_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    ovf_d   = (amount > MAX_AMOUNT);
                    bin_d   = (amount > MAX_AMOUNT) ? MAX_AMOUNT : amount;
                    bcd_d   = 32'd0;
                    iter_d  = 5'd0;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                iter_d = iter_q + 5'd1;
                if (iter_q == LAST_ITER) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                digits_d = bcd_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        // Select and code advance together so the pair is always consistent.
        if (div_q == DIV_LAST) begin
            div_d     = 8'd0;
            sel_d     = sel_next;
            led_bcd_d = disp[sel_next];
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= 27'd0;
            bcd_q     <= 32'd0;
            iter_q    <= 5'd0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            digits_q  <= 32'd0;
            div_q     <= 8'd0;
            sel_q     <= 3'd0;
            led_bcd_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            iter_q    <= iter_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            digits_q  <= digits_d;
            div_q     <= div_d;
            sel_q     <= sel_d;
            led_bcd_q <= led_bcd_d;
        end
    end

    assign busy       = busy_q;
    assign overflow   = ovf_q;
    assign LED_Select = {1'b0, sel_q};
    assign LED_BCD    = led_bcd_q;
endmodule

// File: tb/tb_sev_seg_scanner.sv
// Directed bench for sev_seg_scanner: conversion, blanking, saturation, ignored loads, reset and scan divider.
module tb_sev_seg_scanner;
    logic        clk_1ms = 1'b0;
    logic        rst;
    logic [26:0] amount;
    logic        load;
    logic        blank_lz;
    logic        busy, overflow;
    logic [3:0]  led_sel, led_bcd;
    logic        busy4, overflow4;
    logic [3:0]  led_sel4, led_bcd4;

    int total = 0;
    int bad   = 0;

    always #5 clk_1ms = ~clk_1ms;

    sev_seg_scanner #(.SCAN_DIV(1)) u_dut (
        .clk_1ms(clk_1ms), .rst(rst), .amount(amount), .load(load), .blank_lz(blank_lz),
        .busy(busy), .overflow(overflow), .LED_Select(led_sel), .LED_BCD(led_bcd)
    );

    sev_seg_scanner #(.SCAN_DIV(4)) u_dut4 (
        .clk_1ms(clk_1ms), .rst(rst), .amount(amount), .load(load), .blank_lz(blank_lz),
        .busy(busy4), .overflow(overflow4), .LED_Select(led_sel4), .LED_BCD(led_bcd4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sample 8 consecutive scan slots; with SCAN_DIV=1 this covers every digit once.
    task automatic read_frame(output logic [31:0] f);
        f = 32'h0;
        for (int i = 0; i < 8; i++) begin
            f[led_sel[2:0]*4 +: 4] = led_bcd;
            @(negedge clk_1ms);
        end
    endtask

    // Issue a load, optionally re-pulse load (amount 999) at busy cycle inj, and wait for commit.
    task automatic conv(input logic [26:0] amt, input int inj, output int nbusy, output logic [31:0] mid);
        mid    = 32'h0;
        amount = amt;
        load   = 1'b1;
        @(negedge clk_1ms);
        load  = 1'b0;
        nbusy = 0;
        while (busy && nbusy < 100) begin
            if (nbusy < 8) mid[led_sel[2:0]*4 +: 4] = led_bcd;
            if (nbusy == inj) begin
                amount = 27'd999;
                load   = 1'b1;
            end else begin
                load = 1'b0;
            end
            nbusy++;
            @(negedge clk_1ms);
        end
        load = 1'b0;
        @(negedge clk_1ms);
        $display("load amount=%0d busy_cycles=%0d overflow=%0b", amt, nbusy, overflow);
    endtask

    initial begin
        int          nb;
        logic [31:0] mid, f;

        rst      = 1'b1;
        load     = 1'b0;
        amount   = 27'd0;
        blank_lz = 1'b1;
        repeat (3) @(negedge clk_1ms);
        rst = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k <= 32; k++) begin
            if (k < 8) begin
                check("scan_sel", 32'(led_sel), 32'(k));
                check("scan_bcd", 32'(led_bcd), (k == 0) ? 32'h0 : 32'hF);
            end
            if (k % 4 == 0 || k == 3) check("div4_sel", 32'(led_sel4), 32'((k / 4) % 8));
            @(negedge clk_1ms);
        end

        conv(27'd12_345_678, -1, nb, mid);
        check("basic_busy", 32'(nb), 32'd28);
        check("basic_mid", mid, 32'hFFFF_FFF0);
        check("basic_ovf", 32'(overflow), 32'd0);
        read_frame(f);
        check("basic_frame", f, 32'h1234_5678);

        conv(27'd1_200, -1, nb, mid);
        read_frame(f);
        check("lz_on", f, 32'hFFFF_1200);
        blank_lz = 1'b0;
        @(negedge clk_1ms);
        read_frame(f);
        check("lz_off", f, 32'h0000_1200);
        blank_lz = 1'b1;

        conv(27'd0, -1, nb, mid);
        read_frame(f);
        check("zero", f, 32'hFFFF_FFF0);

        conv(27'd100_000_000, -1, nb, mid);
        check("sat_ovf", 32'(overflow), 32'd1);
        read_frame(f);
        check("sat_frame", f, 32'h9999_9999);
        conv(27'd5, -1, nb, mid);
        check("five_ovf", 32'(overflow), 32'd0);
        read_frame(f);
        check("five_frame", f, 32'hFFFF_FFF5);

        conv(27'd12_345_678, 5, nb, mid);
        check("ign_busy", 32'(nb), 32'd28);
        check("ign_mid", mid, 32'hFFFF_FFF5);
        read_frame(f);
        check("ign_frame", f, 32'h1234_5678);

        conv(27'd777, 27, nb, mid);
        check("commit_busy", 32'(nb), 32'd28);
        check("commit_noload", 32'(busy), 32'd0);
        read_frame(f);
        check("commit_frame", f, 32'hFFFF_F777);

        amount = 27'd100_000_000;
        load   = 1'b1;
        @(negedge clk_1ms);
        load = 1'b0;
        repeat (10) @(negedge clk_1ms);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_ovf", 32'(overflow), 32'd1);
        rst = 1'b1;
        @(negedge clk_1ms);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        check("abort_sel", 32'(led_sel), 32'd0);
        check("abort_bcd", 32'(led_bcd), 32'd0);
        rst = 1'b0;
        read_frame(f);
        check("abort_frame", f, 32'hFFFF_FFF0);
        conv(27'd42, -1, nb, mid);
        check("post_busy", 32'(nb), 32'd28);
        read_frame(f);
        check("post_frame", f, 32'hFFFF_FF42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
